// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - CPU15 register-read stage: register file, two read ports, one valid/ready output register
//
// Purpose
//   Holds the general-purpose register file and serves two read ports per
//   decoded instruction. Both captured indices and operands sit in a single
//   output register with a valid/ready handshake, so decode and execute can
//   stall independently. The write-back port from the last stage updates
//   the file.
//
// Compile-time option
//   REG_READ_BYPASS_EN  defined   : write-first capture of a same-cycle
//                                   write-back, plus refresh of held operands
//                                   while the output is stalled.
//                       undefined : read-before-write capture; held operands
//                                   never change during a stall.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    register index width; file depth NREG = 2**ADDR_W
//   ZERO_REG  when 1, register 0 always reads 0, ignores writes, never bypasses
//
// Ports
//   CLK_DC       in   stage clock, rising edge
//   RESET        in   synchronous, active-high reset
//   IN_VALID     in   decode presents a read request
//   IN_READY     out  stage accepts a request this cycle
//   N_REG_A_IN   in   read port A index
//   N_REG_B_IN   in   read port B index
//   WE           in   write-back enable
//   N_REG_W      in   write-back index
//   REG_W        in   write-back data
//   OUT_VALID    out  output register holds a valid operand pair
//   OUT_READY    in   execute consumes the output this cycle
//   N_REG_A_OUT  out  captured index A
//   N_REG_B_OUT  out  captured index B
//   REG_A_OUT    out  operand A
//   REG_B_OUT    out  operand B

module reg_read_stage #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              CLK_DC,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] N_REG_A_IN,
  input  logic [ADDR_W-1:0] N_REG_B_IN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] N_REG_W,
  input  logic [DATA_W-1:0] REG_W,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] N_REG_A_OUT,
  output logic [ADDR_W-1:0] N_REG_B_OUT,
  output logic [DATA_W-1:0] REG_A_OUT,
  output logic [DATA_W-1:0] REG_B_OUT
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_file [NREG];

  logic              accept;
  logic              write_ok;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  // True for the hard-wired zero register when that option is enabled.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

  // Ready depends only on the output register state and reset, never on
  // IN_VALID, so decode cannot form a combinational loop through us.
  assign IN_READY = !RESET && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign write_ok = WE && !is_zero_reg(N_REG_W);

  // Operand selection for the capture on this edge.
  always_comb begin
    read_a = reg_file[N_REG_A_IN];
    read_b = reg_file[N_REG_B_IN];
`ifdef REG_READ_BYPASS_EN
    // Write-first: a write-back landing on the same edge wins over the
    // stale file contents.
    if (write_ok && (N_REG_W == N_REG_A_IN)) begin
      read_a = REG_W;
    end
    if (write_ok && (N_REG_W == N_REG_B_IN)) begin
      read_b = REG_W;
    end
`endif
    if (is_zero_reg(N_REG_A_IN)) begin
      read_a = '0;
    end
    if (is_zero_reg(N_REG_B_IN)) begin
      read_b = '0;
    end
  end

  // Register file. Reset clears every entry and overrides a pending write.
  always_ff @(posedge CLK_DC) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        reg_file[i] <= '0;
      end
    end else if (write_ok) begin
      reg_file[N_REG_W] <= REG_W;
    end
  end

  // Output pipeline register.
  always_ff @(posedge CLK_DC) begin
    if (RESET) begin
      OUT_VALID   <= 1'b0;
      N_REG_A_OUT <= '0;
      N_REG_B_OUT <= '0;
      REG_A_OUT   <= '0;
      REG_B_OUT   <= '0;
    end else if (accept) begin
      // Covers both fill-from-empty and replace-while-draining.
      OUT_VALID   <= 1'b1;
      N_REG_A_OUT <= N_REG_A_IN;
      N_REG_B_OUT <= N_REG_B_IN;
      REG_A_OUT   <= read_a;
      REG_B_OUT   <= read_b;
    end else if (OUT_VALID && OUT_READY) begin
      // Drain only; data is left as-is for observability.
      OUT_VALID <= 1'b0;
    end else begin
`ifdef REG_READ_BYPASS_EN
      // Stalled: keep held operands coherent with the file so execute
      // never consumes a value that has already been overwritten.
      if (OUT_VALID && write_ok && (N_REG_W == N_REG_A_OUT)) begin
        REG_A_OUT <= REG_W;
      end
      if (OUT_VALID && write_ok && (N_REG_W == N_REG_B_OUT)) begin
        REG_B_OUT <= REG_W;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - self-checking bench for reg_read_stage (ZERO_REG=0 and ZERO_REG=1 side by side)

module tb_reg_read_stage;

`ifdef REG_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        CLK_DC = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic [2:0]  N_REG_A_IN;
  logic [2:0]  N_REG_B_IN;
  logic        WE;
  logic [2:0]  N_REG_W;
  logic [15:0] REG_W;
  logic        OUT_READY;

  logic        ir0, ir1, ov0, ov1;
  logic [2:0]  na0, na1, nb0, nb1;
  logic [15:0] ra0, ra1, rb0, rb1;

  always #5 CLK_DC = ~CLK_DC;

  reg_read_stage #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_dut0 (
    .CLK_DC(CLK_DC), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(ir0),
    .N_REG_A_IN(N_REG_A_IN), .N_REG_B_IN(N_REG_B_IN), .WE(WE), .N_REG_W(N_REG_W),
    .REG_W(REG_W), .OUT_VALID(ov0), .OUT_READY(OUT_READY), .N_REG_A_OUT(na0),
    .N_REG_B_OUT(nb0), .REG_A_OUT(ra0), .REG_B_OUT(rb0)
  );

  reg_read_stage #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) u_dut1 (
    .CLK_DC(CLK_DC), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(ir1),
    .N_REG_A_IN(N_REG_A_IN), .N_REG_B_IN(N_REG_B_IN), .WE(WE), .N_REG_W(N_REG_W),
    .REG_W(REG_W), .OUT_VALID(ov1), .OUT_READY(OUT_READY), .N_REG_A_OUT(na1),
    .N_REG_B_OUT(nb1), .REG_A_OUT(ra1), .REG_B_OUT(rb1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents per instance (index 1
  // is the ZERO_REG instance) plus the expected output register contents.
  logic [15:0] m_rf [2][8];
  logic        m_v;
  logic [2:0]  m_ia, m_ib;
  logic [15:0] m_da [2];
  logic [15:0] m_db [2];

  logic [5:0]  q_out [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value a request to idx should capture this edge, from the architectural rules.
  function automatic logic [15:0] m_read(input int k, input logic [2:0] idx);
    if (k == 1 && idx == 3'd0) return 16'h0000;
    if (BYPASS && WE && N_REG_W == idx && !(k == 1 && N_REG_W == 3'd0)) return REG_W;
    return m_rf[k][idx];
  endfunction

  task automatic drive(input logic iv, input logic [2:0] a, input logic [2:0] b,
                       input logic we, input logic [2:0] w, input logic [15:0] wd,
                       input logic ordy);
    IN_VALID = iv; N_REG_A_IN = a; N_REG_B_IN = b;
    WE = we; N_REG_W = w; REG_W = wd; OUT_READY = ordy;
  endtask

  // One clock: check ready, advance the model, clock the DUTs, check outputs.
  task automatic tick();
    logic        exp_ready, acc;
    logic [15:0] va [2];
    logic [15:0] vb [2];
    #1;
    exp_ready = !RESET && (!m_v || OUT_READY);
    chk("in_ready0", 32'(ir0), 32'(exp_ready));
    chk("in_ready1", 32'(ir1), 32'(exp_ready));
    if (ov0 === 1'b1 && OUT_READY) q_out.push_back({na0, nb0});
    acc = IN_VALID && exp_ready;
    for (int k = 0; k < 2; k++) begin
      va[k] = m_read(k, N_REG_A_IN);
      vb[k] = m_read(k, N_REG_B_IN);
    end
    if (RESET) begin
      m_v = 1'b0; m_ia = 3'd0; m_ib = 3'd0;
      for (int k = 0; k < 2; k++) begin
        m_da[k] = 16'h0; m_db[k] = 16'h0;
        for (int i = 0; i < 8; i++) m_rf[k][i] = 16'h0;
      end
    end else begin
      if (acc) begin
        m_v = 1'b1; m_ia = N_REG_A_IN; m_ib = N_REG_B_IN;
        for (int k = 0; k < 2; k++) begin
          m_da[k] = va[k]; m_db[k] = vb[k];
        end
      end else if (m_v && OUT_READY) begin
        m_v = 1'b0;
      end else if (m_v && BYPASS && WE) begin
        for (int k = 0; k < 2; k++) begin
          if (!(k == 1 && N_REG_W == 3'd0)) begin
            if (N_REG_W == m_ia) m_da[k] = REG_W;
            if (N_REG_W == m_ib) m_db[k] = REG_W;
          end
        end
      end
      if (WE) begin
        for (int k = 0; k < 2; k++) begin
          if (!(k == 1 && N_REG_W == 3'd0)) m_rf[k][N_REG_W] = REG_W;
        end
      end
    end
    @(posedge CLK_DC);
    #1;
    chk("out_valid0", 32'(ov0), 32'(m_v));
    chk("out_valid1", 32'(ov1), 32'(m_v));
    chk("idx_a0", 32'(na0), 32'(m_ia));
    chk("idx_b0", 32'(nb0), 32'(m_ib));
    chk("idx_a1", 32'(na1), 32'(m_ia));
    chk("idx_b1", 32'(nb1), 32'(m_ib));
    chk("reg_a0", 32'(ra0), 32'(m_da[0]));
    chk("reg_b0", 32'(rb0), 32'(m_db[0]));
    chk("reg_a1", 32'(ra1), 32'(m_da[1]));
    chk("reg_b1", 32'(rb1), 32'(m_db[1]));
  endtask

  initial begin
    logic [2:0] req_a [4];
    logic [2:0] req_b [4];
    logic [5:0] got;
    int         idx;
    logic       will_acc;

    m_v = 1'b0; m_ia = 3'd0; m_ib = 3'd0;
    for (int k = 0; k < 2; k++) begin
      m_da[k] = 16'h0; m_db[k] = 16'h0;
      for (int i = 0; i < 8; i++) m_rf[k][i] = 16'h0;
    end

    // Reset for two cycles; IN_READY must be low throughout.
    RESET = 1'b1;
    drive(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 16'hDEAD, 1'b1);
    tick();
    tick();
    chk("reset_valid", 32'(ov0), 32'(0));
    chk("reset_reg_a", 32'(ra0), 32'(0));
    RESET = 1'b0;

    // Reads before any write return 0.
    drive(1'b1, 3'd1, 3'd6, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    chk("pre_write_a", 32'(ra0), 32'(0));
    chk("pre_write_b", 32'(rb0), 32'(0));

    // Write sweep reg[i] = 0x1000+i.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 3'd0, 1'b1, 3'(i), 16'(16'h1000 + i), 1'b1);
      tick();
    end

    // Read pairs (i, 7-i) back to back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 3'(7 - i), 1'b0, 3'd0, 16'h0, 1'b1);
      tick();
      chk("sweep_valid", 32'(ov0), 32'(1));
      chk("sweep_a", 32'(ra0), 32'(16'h1000 + i));
      chk("sweep_b", 32'(rb0), 32'(16'h1007 - i));
    end
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    chk("sweep_drained", 32'(ov0), 32'(0));

    // Four back-to-back requests; execute stalls for three cycles after the 2nd.
    req_a = '{3'd4, 3'd5, 3'd6, 3'd7};
    req_b = '{3'd3, 3'd2, 3'd1, 3'd0};
    q_out.delete();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) drive(1'b1, req_a[idx], req_b[idx], 1'b0, 3'd0, 16'h0, !(c >= 2 && c <= 4));
      else         drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
      will_acc = IN_VALID && !RESET && (!m_v || OUT_READY);
      tick();
      if (will_acc) idx++;
      if (c >= 2 && c <= 4) chk("stall_hold_idx", 32'(na0), 32'(5));
      if (idx == 4 && !m_v) break;
    end
    chk("b2b_count", 32'(q_out.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      got = (i < q_out.size()) ? q_out[i] : 6'h3F;
      chk("b2b_order", 32'(got), 32'({req_a[i], req_b[i]}));
    end

    // Same-cycle write and read of reg 3.
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 16'h00AA, 1'b1);
    tick();
    drive(1'b1, 3'd3, 3'd3, 1'b1, 3'd3, 16'h5555, 1'b1);
    tick();
    chk("rw_same_a", 32'(ra0), 32'(BYPASS ? 16'h5555 : 16'h00AA));
    chk("rw_same_b", 32'(rb0), 32'(BYPASS ? 16'h5555 : 16'h00AA));

    // Stall refresh of a held operand.
    drive(1'b1, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 16'hBEEF, 1'b0);
    tick();
    chk("refresh_a", 32'(ra0), 32'(BYPASS ? 16'hBEEF : 16'h1002));
    chk("refresh_b", 32'(rb0), 32'(16'h1005));
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    tick();
    chk("refresh_hold", 32'(ra0), 32'(BYPASS ? 16'hBEEF : 16'h1002));
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();

    // Register 0 on the ZERO_REG instance.
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1);
    tick();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    chk("zero_reg_a", 32'(ra1), 32'(0));
    chk("zero_reg_b", 32'(rb1), 32'(0));
    drive(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 16'h1234, 1'b1);
    tick();
    chk("zero_reg_bypass", 32'(ra1), 32'(0));

    // Reset while stalled with a write pending.
    drive(1'b1, 3'd4, 3'd6, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    tick();
    RESET = 1'b1;
    drive(1'b1, 3'd1, 3'd1, 1'b1, 3'd1, 16'h1234, 1'b0);
    tick();
    chk("rst_stall_valid", 32'(ov0), 32'(0));
    chk("rst_stall_a", 32'(ra0), 32'(0));
    chk("rst_stall_b", 32'(rb0), 32'(0));
    chk("rst_stall_ready", 32'(ir0), 32'(0));
    RESET = 1'b0;
    drive(1'b1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b1);
    tick();
    chk("rst_write_dropped", 32'(ra0), 32'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Parametrised register-read stage for the CPU15 pipeline: holds the general-purpose register file and serves two read ports per instruction. Results go into a single output pipeline register with a valid/ready handshake, so decode and execute can stall independently. The stage sits between instruction decode and execute and accepts the write-back port from the last stage. A compile-time bypass forwards same-cycle write-back data into the captured operands.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; file depth NREG = 2**ADDR_W
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes

Ports:
- CLK_DC  in  1  stage clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  decode presents a read request
- IN_READY  out  1  stage accepts request this cycle
- N_REG_A_IN  in  ADDR_W  read port A index
- N_REG_B_IN  in  ADDR_W  read port B index
- WE  in  1  write-back enable
- N_REG_W  in  ADDR_W  write-back index
- REG_W  in  DATA_W  write-back data
- OUT_VALID  out  1  output register holds a valid operand pair
- OUT_READY  in  1  execute consumes output this cycle
- N_REG_A_OUT  out  ADDR_W  captured index A
- N_REG_B_OUT  out  ADDR_W  captured index B
- REG_A_OUT  out  DATA_W  operand A
- REG_B_OUT  out  DATA_W  operand B

## Operation
- Register file: NREG x DATA_W flops. On a clock edge with WE=1 and RESET=0, reg[N_REG_W] <= REG_W. With ZERO_REG=1, writes to index 0 are dropped and index 0 reads 0.
- IN_READY = !RESET && (!OUT_VALID || OUT_READY), combinational.
- Accept: IN_VALID && IN_READY. On accept the output register captures both indices and both read values, and OUT_VALID <= 1.
- Drain without accept: OUT_VALID && OUT_READY && !accept sets OUT_VALID <= 0. The data outputs keep their last values.
- Accept and drain in the same cycle: OUT_VALID stays 1 and the new data replaces the old, giving full throughput.
- Stall: OUT_VALID=1 and OUT_READY=0. All outputs hold, except for the held-operand refresh described under Configuration.
- Both ports may name the same index, and each returns the same value.
- Reset: all file entries become 0, OUT_VALID=0, N_REG_A_OUT=N_REG_B_OUT=0 and REG_A_OUT=REG_B_OUT=0. Reset takes priority over WE and accept on the same edge. Reset asserted mid-stall discards the held operands.

## Timing
- Read latency is 1 cycle: operands accepted at edge n are visible on the outputs after edge n.
- A write at edge n is visible to any request accepted at edge n+1 or later, with or without bypass.
- IN_READY depends only on OUT_VALID, OUT_READY and RESET. It has no combinational path from IN_VALID.
- There is no combinational path from any input to REG_A_OUT or REG_B_OUT.

## Configuration
- REG_READ_BYPASS_EN defined:
  - Write-first capture: on accept with WE=1 and N_REG_W equal to a read index, that port captures REG_W instead of the stale file value.
  - Held-operand refresh: while OUT_VALID=1 and the output is not being replaced, a write whose N_REG_W equals N_REG_A_OUT or N_REG_B_OUT also updates REG_A_OUT or REG_B_OUT.
  - With ZERO_REG=1, index 0 is never bypassed.
- REG_READ_BYPASS_EN undefined:
  - Read-before-write capture: an accept on the same edge as a matching write captures the old value.
  - Held outputs never change during a stall.
  - Execute-side forwarding is then required elsewhere.

## Test plan
- Reset then write sweep: assert RESET for 2 cycles, write reg[i] = 16'h1000+i for i=0..7, then read pairs (i, 7-i). Required: OUT_VALID pulses one cycle after each accept and REG_A_OUT = 16'h1000+i, REG_B_OUT = 16'h1007-i. Before any write, reads return 0.
- Back-to-back with stall: 4 consecutive accepts with OUT_READY held 0 from the 2nd cycle for 3 cycles. Required: IN_READY=0 during the stall, outputs hold the 2nd request, nothing is lost or duplicated, and order is preserved.
- Same-cycle write/read of reg 3 (old value 16'h00AA, new value 16'h5555). Required: REG_A_OUT = 16'h5555 with REG_READ_BYPASS_EN defined, and 16'h00AA without it.
- Stall refresh: hold output (A=2) with OUT_READY=0 and write reg 2 = 16'hBEEF. Required: REG_A_OUT becomes 16'hBEEF on the next cycle with the macro defined, and is unchanged without it.
- ZERO_REG=1: write reg 0 = 16'hFFFF, then read (0,0). Required: both outputs 0 in both configurations.
- Reset mid-stall while OUT_VALID=1 and WE=1. Required: after the edge OUT_VALID=0, all outputs 0, the write is dropped, and IN_READY=0 while RESET is high.
